clock_core_param: RTL and testbench

Parametrised time-keeping core for the digital clock project. It holds hours, minutes and seconds, and advances them from a configurable prescaler. It provides a button-driven set mode with per-field increment and decrement, runtime 12/24-hour display selection, and blink-gated field flash flags. Its outputs are registered BCD digits that feed the existing seven-segment display controller.

---
 rtl/clock_pkg.sv | 26 ++
 rtl/clock_core_param_tick_gen.sv | 27 ++
 rtl/clock_core_param.sv | 184 ++++++++++++++++++
 tb/tb_clock_core_param.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared types, field indices, limits and BCD helper for the clock core.
package clock_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        SET_H = 2'd1,
        SET_M = 2'd2,
        SET_S = 2'd3
    } state_t;

    localparam int unsigned F_HOUR = 2;
    localparam int unsigned F_MIN  = 1;
    localparam int unsigned F_SEC  = 0;

    localparam int unsigned SEC_MAX  = 59;
    localparam int unsigned MIN_MAX  = 59;
    localparam int unsigned HOUR_MAX = 23;

    // Two-digit BCD of a value 0..99.
    function automatic logic [7:0] bin_to_bcd2(input logic [6:0] bin);
        logic [7:0] b8;
        b8 = {1'b0, bin};
        return ((b8 / 8'd10) << 4) | (b8 % 8'd10);
    endfunction

endpackage

// File: rtl/clock_core_param_tick_gen.sv
// One-second prescaler; held at 0 while hold is high, cleared by clear.
module clock_tick_gen #(
    parameter int unsigned TICKS_PER_SEC = 50000000
) (
    input  logic clk,
    input  logic reset,
    input  logic hold,
    input  logic clear,
    output logic sec_tick_c
);
    localparam int unsigned CW = $clog2(TICKS_PER_SEC);

    logic [CW-1:0] cnt_q;
    logic          at_top;

    assign at_top     = (cnt_q == CW'(TICKS_PER_SEC - 1));
    assign sec_tick_c = ~hold & at_top;

    always_ff @(posedge clk) begin
        if (!reset || hold || clear || at_top) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/clock_core_param.sv
// Time-keeping core: counters, set FSM, blink flags and registered BCD outputs.
module clock_core_param
    import clock_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC = 50000000,
    parameter int unsigned BLINK_TICKS   = 12500000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mode,
    input  logic        set,
    input  logic        op1,
    input  logic        op2,
    output logic [23:0] time_bcd,
    output logic [2:0]  flash,
    output logic        pm,
    output logic        mode12,
    output logic        editing
);
    localparam int unsigned BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    state_t        state_q, state_d;
    logic [5:0]    sec_q, sec_d, min_q, min_d;
    logic [4:0]    hour_q, hour_d;
    logic [BW-1:0] blink_q, blink_d;
    logic          phase_q, phase_d;
    logic          mode12_q, mode12_d;
    logic          prev_mode, prev_set, prev_op1, prev_op2;
    logic          pulse_mode, pulse_set, pulse_op1, pulse_op2;
    logic          edit_up, edit_any;
    logic          sec_tick_c;
    logic [4:0]    hour_disp;
    logic [23:0]   time_bcd_d;
    logic [2:0]    flash_d;
    logic          pm_d;

    assign pulse_mode = mode & ~prev_mode;
    assign pulse_set  = set  & ~prev_set;
    assign pulse_op1  = op1  & ~prev_op1;
    assign pulse_op2  = op2  & ~prev_op2;
    assign edit_up    = pulse_op1 & ~pulse_op2;
    assign edit_any   = pulse_op1 ^ pulse_op2;

    clock_tick_gen #(
        .TICKS_PER_SEC(TICKS_PER_SEC)
    ) u_tick_gen (
        .clk       (clk),
        .reset     (reset),
        .hold      (state_q != RUN),
        .clear     (pulse_set && (state_q == SET_S)),
        .sec_tick_c(sec_tick_c)
    );

    // Modulo step up or down within 0..max, no carry.
    function automatic logic [5:0] wrap_step(input logic [5:0] v, input logic [5:0] max,
                                             input logic up);
        if (up) begin
            return (v == max) ? 6'd0 : v + 6'd1;
        end
        return (v == 6'd0) ? max : v - 6'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= RUN;
            sec_q     <= '0;
            min_q     <= '0;
            hour_q    <= '0;
            blink_q   <= '0;
            phase_q   <= 1'b0;
            mode12_q  <= 1'b0;
            prev_mode <= 1'b0;
            prev_set  <= 1'b0;
            prev_op1  <= 1'b0;
            prev_op2  <= 1'b0;
            time_bcd  <= '0;
            flash     <= '0;
            pm        <= 1'b0;
            mode12    <= 1'b0;
            editing   <= 1'b0;
        end else begin
            state_q   <= state_d;
            sec_q     <= sec_d;
            min_q     <= min_d;
            hour_q    <= hour_d;
            blink_q   <= blink_d;
            phase_q   <= phase_d;
            mode12_q  <= mode12_d;
            prev_mode <= mode;
            prev_set  <= set;
            prev_op1  <= op1;
            prev_op2  <= op2;
            time_bcd  <= time_bcd_d;
            flash     <= flash_d;
            pm        <= pm_d;
            mode12    <= mode12_q;
            editing   <= (state_q != RUN);
        end
    end

    // Next state, field edits, time carry and blink.
    always_comb begin
        state_d  = state_q;
        sec_d    = sec_q;
        min_d    = min_q;
        hour_d   = hour_q;
        blink_d  = blink_q;
        phase_d  = phase_q;
        mode12_d = mode12_q ^ pulse_mode;

        unique case (state_q)
            RUN: begin
                if (pulse_set) state_d = SET_H;
            end
            SET_H: begin
                if (pulse_set) begin
                    state_d = SET_M;
                end else if (edit_any) begin
                    hour_d = 5'(wrap_step({1'b0, hour_q}, 6'(HOUR_MAX), edit_up));
                end
            end
            SET_M: begin
                if (pulse_set) begin
                    state_d = SET_S;
                end else if (edit_any) begin
                    min_d = wrap_step(min_q, 6'(MIN_MAX), edit_up);
                end
            end
            SET_S: begin
                if (pulse_set) begin
                    state_d = RUN;
                end else if (edit_any) begin
                    sec_d = wrap_step(sec_q, 6'(SEC_MAX), edit_up);
                end
            end
            default: state_d = RUN;
        endcase

        if ((state_q == RUN) && sec_tick_c) begin
            sec_d = wrap_step(sec_q, 6'(SEC_MAX), 1'b1);
            if (sec_q == 6'(SEC_MAX)) begin
                min_d = wrap_step(min_q, 6'(MIN_MAX), 1'b1);
                if (min_q == 6'(MIN_MAX)) begin
                    hour_d = 5'(wrap_step({1'b0, hour_q}, 6'(HOUR_MAX), 1'b1));
                end
            end
        end

        if (pulse_set && (state_q != SET_S)) begin
            blink_d = '0;
            phase_d = 1'b0;
        end else if (state_q != RUN) begin
            if (blink_q == BW'(BLINK_TICKS - 1)) begin
                blink_d = '0;
                phase_d = ~phase_q;
            end else begin
                blink_d = blink_q + BW'(1);
            end
        end
    end

    // Display conversion feeding the output registers.
    always_comb begin
        hour_disp = hour_q;
        if (mode12_q) begin
            if ((hour_q == 5'd0) || (hour_q == 5'd12)) begin
                hour_disp = 5'd12;
            end else if (hour_q > 5'd12) begin
                hour_disp = hour_q - 5'd12;
            end
        end
        pm_d       = mode12_q && (hour_q >= 5'd12);
        time_bcd_d = {bin_to_bcd2(7'(hour_disp)), bin_to_bcd2(7'(min_q)),
                      bin_to_bcd2(7'(sec_q))};
        flash_d = '0;
        unique case (state_q)
            SET_H:   flash_d[F_HOUR] = phase_q;
            SET_M:   flash_d[F_MIN]  = phase_q;
            SET_S:   flash_d[F_SEC]  = phase_q;
            default: flash_d = '0;
        endcase
    end

endmodule

// File: tb/tb_clock_core_param.sv
// Directed bench for clock_core_param with a short prescaler and blink period.
module tb_clock_core_param;
    localparam int unsigned TPS = 4;
    localparam int unsigned BT  = 2;

    localparam logic [3:0] B_MODE = 4'b1000;
    localparam logic [3:0] B_SET  = 4'b0100;
    localparam logic [3:0] B_OP1  = 4'b0010;
    localparam logic [3:0] B_OP2  = 4'b0001;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mode = 1'b0, set = 1'b0, op1 = 1'b0, op2 = 1'b0;
    logic [23:0] time_bcd;
    logic [2:0]  flash;
    logic        pm, mode12, editing;

    int total = 0;
    int bad   = 0;

    clock_core_param #(
        .TICKS_PER_SEC(TPS),
        .BLINK_TICKS  (BT)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .mode    (mode),
        .set     (set),
        .op1     (op1),
        .op2     (op2),
        .time_bcd(time_bcd),
        .flash   (flash),
        .pm      (pm),
        .mode12  (mode12),
        .editing (editing)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One-cycle press of the buttons in mask {mode,set,op1,op2}, then release.
    task automatic press(input logic [3:0] mask);
        {mode, set, op1, op2} = mask;
        step(1);
        {mode, set, op1, op2} = 4'b0000;
        step(1);
    endtask

    task automatic do_reset();
        {mode, set, op1, op2} = 4'b0000;
        reset = 1'b0;
        step(2);
        reset = 1'b1;
    endtask

    logic [2:0] flash_exp [6];

    initial begin
        flash_exp = '{3'b000, 3'b100, 3'b100, 3'b000, 3'b000, 3'b100};

        // Reset state and free-running count
        reset = 1'b0;
        step(2);
        check("rst_time", 32'(time_bcd), 32'h000000);
        check("rst_flash", 32'(flash), 32'h0);
        check("rst_pm", 32'(pm), 32'h0);
        check("rst_mode12", 32'(mode12), 32'h0);
        check("rst_editing", 32'(editing), 32'h0);
        reset = 1'b1;
        step(TPS * 61 + 1);
        check("run_61s", 32'(time_bcd), 32'h000101);
        check("run_mode12", 32'(mode12), 32'h0);
        check("run_flash", 32'(flash), 32'h0);

        // Set and blink
        do_reset();
        press(B_SET);
        check("set_editing", 32'(editing), 32'h1);
        check("set_flash0", 32'(flash), 32'h0);
        for (int i = 0; i < 6; i++) begin
            step(1);
            check($sformatf("blink_%0d", i), 32'(flash), 32'(flash_exp[i]));
        end
        press(B_OP2);
        check("hour_dec_wrap", 32'(time_bcd), 32'h230000);
        op1 = 1'b1;
        step(10);
        op1 = 1'b0;
        step(1);
        check("hour_held_inc", 32'(time_bcd), 32'h000000);
        press(B_SET);
        check("set_m_editing", 32'(editing), 32'h1);
        press(B_SET);
        press(B_SET);
        check("exit_editing", 32'(editing), 32'h0);
        check("exit_flash", 32'(flash), 32'h0);

        // Midnight wrap
        do_reset();
        press(B_SET);
        press(B_OP2);
        press(B_SET);
        press(B_OP2);
        press(B_SET);
        press(B_OP2);
        press(B_SET);
        check("wrap_start", 32'(time_bcd), 32'h235959);
        for (int i = 0; i < 3; i++) begin
            step(1);
            check($sformatf("wrap_hold_%0d", i), 32'(time_bcd), 32'h235959);
        end
        step(1);
        check("wrap_midnight", 32'(time_bcd), 32'h000000);
        check("wrap_editing", 32'(editing), 32'h0);

        // Simultaneous pulses
        do_reset();
        press(B_SET);
        press(B_OP1);
        check("sim_hour1", 32'(time_bcd), 32'h010000);
        press(B_SET | B_OP1);
        check("sim_set_op1", 32'(time_bcd), 32'h010000);
        press(B_OP1);
        check("sim_min1", 32'(time_bcd), 32'h010100);
        press(B_OP1 | B_OP2);
        check("sim_op1_op2", 32'(time_bcd), 32'h010100);
        check("sim_editing", 32'(editing), 32'h1);

        // 12-hour display
        do_reset();
        press(B_MODE);
        check("h12_midnight", 32'(time_bcd), 32'h120000);
        check("h12_pm0", 32'(pm), 32'h0);
        check("h12_mode12", 32'(mode12), 32'h1);
        press(B_SET);
        for (int i = 0; i < 11; i++) press(B_OP2);
        check("h12_13", 32'(time_bcd), 32'h010000);
        check("h12_13_pm", 32'(pm), 32'h1);
        press(B_OP2);
        check("h12_noon", 32'(time_bcd), 32'h120000);
        check("h12_noon_pm", 32'(pm), 32'h1);
        press(B_OP1);
        press(B_MODE);
        check("h24_13", 32'(time_bcd), 32'h130000);
        check("h24_pm", 32'(pm), 32'h0);
        check("h24_mode12", 32'(mode12), 32'h0);

        // Reset mid-edit
        do_reset();
        press(B_SET);
        press(B_SET);
        for (int i = 0; i < 37; i++) press(B_OP1);
        check("edit_min37", 32'(time_bcd), 32'h003700);
        check("edit_active", 32'(editing), 32'h1);
        reset = 1'b0;
        step(1);
        check("mid_rst_editing", 32'(editing), 32'h0);
        check("mid_rst_time", 32'(time_bcd), 32'h000000);
        check("mid_rst_flash", 32'(flash), 32'h0);
        reset = 1'b1;
        step(1);
        check("post_rst_time", 32'(time_bcd), 32'h000000);
        check("post_rst_editing", 32'(editing), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
